// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, ALU and
// result-select encodings, and the per-instruction control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  // ALU_AUIPC is an add whose A operand is the PC instead of RD1.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;
  } ctrl_t;

  // funct3 -> ALU op; alt selects sub/sra (funct7[5]) where it applies.
  function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_ctrl_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: x0 hardwired to zero, write-through bypass
// so a same-cycle writeback is visible to decode, cleared on reset.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_W     = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr1_i,
  input  logic [ADDR_W-1:0]     raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
  logic [ADDR_W-1:0]     raddr [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  wr_en;

  assign wr_en    = we_i && (waddr_i != '0);
  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;
  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

  // Storage: reset clears every entry and beats any in-flight writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      // Read port: x0 is zero, a matching writeback is forwarded.
      always_comb begin
        rdata[gi] = mem_q[raddr[gi]];
        if (raddr[gi] == '0) begin
          rdata[gi] = '0;
        end else if (wr_en && (waddr_i == raddr[gi])) begin
          rdata[gi] = wdata_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, immediate extension, control generation and
// the decode/execute pipeline register. Unknown opcodes decode as bubbles.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flushE,
  input  logic [DATA_WIDTH-1:0] InstrD,
  input  logic [DATA_WIDTH-1:0] PCounterD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  RegWriteW,
  input  logic [4:0]            RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic [DATA_WIDTH-1:0] PCounterE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [3:0]            ALUControlE,
  output logic [2:0]            Funct3E
);

  localparam int ADDR_W = $clog2(REG_COUNT);

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rd_d;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_d;
  imm_src_t              imm_src;
  ctrl_t                 ctrl_d;

  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [4:0]            rs1_q, rs2_q, rd_q;
  logic [2:0]            funct3_q;
  ctrl_t                 ctrl_q;

  assign instr  = InstrD[31:0];
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd_d   = instr[11:7];
  assign Rs1D   = instr[19:15];
  assign Rs2D   = instr[24:20];

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ADDR_W     (ADDR_W)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we_i     (RegWriteW),
    .waddr_i  (RdW[ADDR_W-1:0]),
    .wdata_i  (ResultW),
    .raddr1_i (Rs1D[ADDR_W-1:0]),
    .raddr2_i (Rs2D[ADDR_W-1:0]),
    .rdata1_o (rd1_d),
    .rdata2_o (rd2_d)
  );

  // Main control decode; anything unrecognised leaves every enable low.
  always_comb begin
    ctrl_d  = '{reg_write: 1'b0, mem_write: 1'b0, jump: 1'b0, branch: 1'b0,
                alu_src: 1'b0, result_src: RES_ALU, alu_ctrl: ALU_ADD};
    imm_src = IMM_I;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = alu_decode(funct3, instr[30]);
      end
      OP_I: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        // Only shifts-right read funct7[5]; addi never becomes sub.
        ctrl_d.alu_ctrl  = alu_decode(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
      end
      OP_STORE: begin
        imm_src          = IMM_S;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        imm_src         = IMM_B;
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        imm_src           = IMM_J;
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_PC4;
      end
      OP_LUI: begin
        imm_src          = IMM_U;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        imm_src          = IMM_U;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_AUIPC;
      end
      default: ;
    endcase
  end

  // Immediate extraction per format, then sign-extension to the datapath.
  always_comb begin
    case (imm_src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_d = DATA_WIDTH'($signed(imm32));
  end

  // Decode/execute register: reset or flush both load a bubble.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      pc4_q    <= '0;
      funct3_q <= '0;
      ctrl_q   <= '0;
    end else begin
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs1_q    <= Rs1D;
      rs2_q    <= Rs2D;
      rd_q     <= rd_d;
      pc_q     <= PCounterD;
      pc4_q    <= PCPlus4D;
      funct3_q <= funct3;
      ctrl_q   <= ctrl_d;
    end
  end

  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign PCounterE   = pc_q;
  assign PCPlus4E    = pc4_q;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_ctrl;
  assign Funct3E     = funct3_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset/clear sequence, a vector table
// covering decode, bypass, x0 and immediates, and a flush-with-writeback case.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flushE, RegWriteW;
  logic [31:0] InstrD, PCounterD, PCPlus4D, ResultW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCounterE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .flushE(flushE), .InstrD(InstrD),
    .PCounterD(PCounterD), .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .PCounterE(PCounterE), .PCPlus4E(PCPlus4E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E)
  );

  // ctl = {RegWrite, MemWrite, Jump, Branch, ALUSrc}
  typedef struct {
    logic [31:0] instr;
    logic        flush;
    logic        we;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        chk_imm;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [4:0]  ctl;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [2:0]  f3;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  function automatic logic [255:0] pack_out(input logic with_imm);
    return {RD1E, RD2E, (with_imm ? ImmExtE : 32'h0), Rs1E, Rs2E, RdE,
            PCounterE, PCPlus4E, RegWriteE, MemWriteE, JumpE, BranchE,
            ALUSrcE, ResultSrcE, ALUControlE, Funct3E};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp;
    logic [31:0]  pc;
    string        nm;

    vt[0]  = '{32'h00000013, 0, 1, 5'd3, 32'h1234,      1, 0, 0, 0, 0, 0, 0, 5'b10001, 2'b00, ALU_ADD, 3'd0};
    vt[1]  = '{32'h000180B3, 0, 0, 5'd0, 32'h0,         0, 32'h1234, 0, 0, 3, 0, 1, 5'b10000, 2'b00, ALU_ADD, 3'd0};
    vt[2]  = '{32'h00338133, 0, 1, 5'd7, 32'hCAFE,      0, 32'hCAFE, 32'h1234, 0, 7, 3, 2, 5'b10000, 2'b00, ALU_ADD, 3'd0};
    vt[3]  = '{32'h40338233, 0, 0, 5'd0, 32'h0,         0, 32'hCAFE, 32'h1234, 0, 7, 3, 4, 5'b10000, 2'b00, ALU_SUB, 3'd0};
    vt[4]  = '{32'h000000B3, 0, 1, 5'd0, 32'hFFFFFFFF,  0, 0, 0, 0, 0, 0, 1, 5'b10000, 2'b00, ALU_ADD, 3'd0};
    vt[5]  = '{32'h000000B3, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 5'b10000, 2'b00, ALU_ADD, 3'd0};
    vt[6]  = '{32'hFE000EE3, 0, 0, 5'd0, 32'h0,         1, 0, 0, 32'hFFFFFFFC, 0, 0, 29, 5'b00010, 2'b00, ALU_SUB, 3'd0};
    vt[7]  = '{32'hFE000EE3, 1, 0, 5'd0, 32'h0,         1, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, ALU_ADD, 3'd0};
    vt[8]  = '{32'h123452B7, 0, 0, 5'd0, 32'h0,         1, 0, 32'h1234, 32'h12345000, 8, 3, 5, 5'b10001, 2'b00, ALU_PASSB, 3'd5};
    vt[9]  = '{32'hFE312E23, 0, 0, 5'd0, 32'h0,         1, 0, 32'h1234, 32'hFFFFFFFC, 2, 3, 28, 5'b01001, 2'b00, ALU_ADD, 3'd2};
    vt[10] = '{32'h001000EF, 0, 0, 5'd0, 32'h0,         1, 0, 0, 32'h800, 0, 1, 1, 5'b10100, 2'b10, ALU_ADD, 3'd0};
    vt[11] = '{32'h0000007F, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, ALU_ADD, 3'd0};
    vt[12] = '{32'hFFF18313, 0, 0, 5'd0, 32'h0,         1, 32'h1234, 0, 32'hFFFFFFFF, 3, 31, 6, 5'b10001, 2'b00, ALU_ADD, 3'd0};
    vt[13] = '{32'h4041D313, 0, 0, 5'd0, 32'h0,         1, 32'h1234, 0, 32'h404, 3, 4, 6, 5'b10001, 2'b00, ALU_SRA, 3'd5};
    vt[14] = '{32'h0041D313, 0, 0, 5'd0, 32'h0,         1, 32'h1234, 0, 32'h4, 3, 4, 6, 5'b10001, 2'b00, ALU_SRL, 3'd5};
    vt[15] = '{32'h0071C433, 0, 0, 5'd0, 32'h0,         0, 32'h1234, 32'hCAFE, 0, 3, 7, 8, 5'b10000, 2'b00, ALU_XOR, 3'd4};
    vt[16] = '{32'h0081A483, 0, 0, 5'd0, 32'h0,         1, 32'h1234, 0, 32'h8, 3, 8, 9, 5'b10001, 2'b01, ALU_ADD, 3'd2};
    vt[17] = '{32'h00001517, 0, 0, 5'd0, 32'h0,         1, 0, 0, 32'h1000, 0, 0, 10, 5'b10001, 2'b00, ALU_AUIPC, 3'd1};
    vt[18] = '{32'h000180E7, 0, 0, 5'd0, 32'h0,         1, 32'h1234, 0, 0, 3, 0, 1, 5'b10101, 2'b10, ALU_ADD, 3'd0};
    vt[19] = '{32'h0071B5B3, 0, 0, 5'd0, 32'h0,         0, 32'h1234, 32'hCAFE, 0, 3, 7, 11, 5'b10000, 2'b00, ALU_SLTU, 3'd3};

    // Power-on reset.
    rst = 1'b1; flushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    InstrD = '0; PCounterD = '0; PCPlus4D = '0;
    repeat (2) @(posedge clk);
    #1;

    // Put a value in x5 and confirm it reads back.
    rst = 1'b0; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h55;
    @(posedge clk); #1;
    RegWriteW = 1'b0; InstrD = 32'h000280B3; PCounterD = 32'h40; PCPlus4D = 32'h44;
    @(posedge clk); #1;
    check("x5_written", {224'h0, RD1E}, {224'h0, 32'h55});

    // Reset with a writeback in flight: E bubble, write lost, x5 cleared.
    rst = 1'b1; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD;
    InstrD = 32'h000180B3;
    @(posedge clk); #1;
    check("rst_E_zero", pack_out(1'b1), 256'h0);
    rst = 1'b0; RegWriteW = 1'b0; InstrD = 32'h000280B3;
    @(posedge clk); #1;
    check("x5_cleared", {224'h0, RD1E}, 256'h0);
    check("after_rst_ctl", {248'h0, RdE, RegWriteE, ALUSrcE, JumpE}, {248'h0, 5'd1, 1'b1, 1'b0, 1'b0});

    // Table-driven single-instruction vectors.
    for (int i = 0; i < NV; i++) begin
      pc        = 32'h1000 + 32'(i * 4);
      InstrD    = vt[i].instr;
      flushE    = vt[i].flush;
      RegWriteW = vt[i].we;
      RdW       = vt[i].rdw;
      ResultW   = vt[i].resw;
      PCounterD = pc;
      PCPlus4D  = pc + 32'd4;
      #1;
      nm = $sformatf("v%0d_rsD", i);
      check(nm, {246'h0, Rs1D, Rs2D}, {246'h0, vt[i].instr[19:15], vt[i].instr[24:20]});
      @(posedge clk); #1;
      exp = {vt[i].rd1, vt[i].rd2, vt[i].imm, vt[i].rs1, vt[i].rs2, vt[i].rd,
             (vt[i].flush ? 32'h0 : pc), (vt[i].flush ? 32'h0 : pc + 32'd4),
             vt[i].ctl, vt[i].rsrc, vt[i].alu, vt[i].f3};
      nm = $sformatf("v%0d_E_%08h", i, vt[i].instr);
      check(nm, pack_out(vt[i].chk_imm), exp);
    end

    // Flush still lets the writeback land in the register file.
    flushE = 1'b1; RegWriteW = 1'b1; RdW = 5'd12; ResultW = 32'h777;
    InstrD = 32'h000600B3; PCounterD = 32'h2000; PCPlus4D = 32'h2004;
    @(posedge clk); #1;
    check("flush_bubble", {224'h0, RD1E, RegWriteE, PCounterE[0]}, 256'h0);
    flushE = 1'b0; RegWriteW = 1'b0;
    @(posedge clk); #1;
    check("flush_wb_kept", {224'h0, RD1E}, {224'h0, 32'h777});
    check("flush_next_pc", {224'h0, PCounterE}, {224'h0, 32'h2000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage: consumes InstrD/PCounterD/PCPlus4D from the fetch/decode pipe.
- Reads the register file, extends the immediate and generates control.
- Registers everything into the decode/execute pipeline register feeding execute.
- Also hosts the architectural register file, written from writeback.

Parameters:
- DATA_WIDTH, 32, datapath/PC/instruction width (≥32 for RV32I encodings)
- REG_COUNT, 32, architectural registers; address width is $clog2(REG_COUNT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flushE  in  1  replace next E-register contents with bubble
- InstrD  in  DATA_WIDTH  instruction in decode
- PCounterD  in  DATA_WIDTH  PC of InstrD
- PCPlus4D  in  DATA_WIDTH  PC+4 of InstrD
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  DATA_WIDTH  writeback data
- Rs1D, Rs2D  out  5  decode source indices (combinational, to hazard unit)
- RD1E, RD2E  out  DATA_WIDTH  registered operands
- ImmExtE  out  DATA_WIDTH  registered extended immediate
- Rs1E, Rs2E, RdE  out  5  registered register indices
- PCounterE, PCPlus4E  out  DATA_WIDTH  registered PC values
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  4  ALU operation (package encoding)
- Funct3E  out  3  branch/load-store qualifier

Behaviour:
- Register file: REG_COUNT×DATA_WIDTH, write on rising clk when RegWriteW and RdW≠0.
- x0 always reads 0; writes to x0 ignored.
- Same-cycle bypass: if RegWriteW, RdW≠0 and RdW equals a read index, that read returns ResultW. The register file is write-through.
- Immediate by ImmSrc:
  - I: sign-extended [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - All sign-extended to DATA_WIDTH.
- Decoded set:
  - R-type: add, sub, and, or, xor, slt, sltu, sll, srl, sra
  - I-ALU: same ops minus sub; shifts use funct7[5] for srai
  - Loads (lw): ResultSrc 01, ALUSrc 1
  - Stores (sw): MemWrite 1, ALUSrc 1
  - Branches: all funct3, Branch 1, ALU sub
  - jal, jalr: Jump 1, ResultSrc 10, RegWrite 1
  - lui: ALU pass-B; auipc: ALU add with PC operand flag encoded in ALUControl
- Unknown opcode: all enables 0 (RegWrite, MemWrite, Jump, Branch). Treated as a bubble; no X propagation.
- Latency: one cycle. D-side values at edge N appear on the E outputs after edge N.
- E register update priority:
  - rst: all E outputs 0, and all register-file entries cleared to 0 in the same edge.
  - flushE: all E outputs 0 (bubble). Register-file writes still occur.
  - Otherwise: capture D-side values.
- rst asserted mid-operation overrides an in-flight writeback. That write is lost.
- No stallE: execute never stalls in this pipeline.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - imm_src_t enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J)
  - alu_ctrl_t 4-bit enum
  - result_src_t enum
- One natural sub-module: reg_file (storage, x0 rule, bypass).
- Control decode and immediate extension stay inline as combinational blocks.
- The E register is inline.

Test Plan:
- Reset with RegWriteW=1, RdW=5, ResultW=0xDEAD → after edge, all E outputs 0 and x5 reads 0 next cycle.
- Write x3=0x1234 via W, then InstrD=add x1,x3,x0 (0x000180B3) → RD1E=0x1234, RD2E=0, RdE=1, RegWriteE=1, ALUControlE=ADD.
- Same cycle: RegWriteW=1, RdW=7, ResultW=0xCAFE with InstrD reading rs1=x7 → RD1E=0xCAFE (bypass).
- RdW=0, ResultW=0xFFFF_FFFF, RegWriteW=1, then read x0 → RD1E=0.
- beq with negative offset (0xFE000EE3) → ImmExtE=0xFFFF_FFFC, BranchE=1, Funct3E=000; same instruction with flushE=1 → all E controls 0.
- Immediate coverage:
  - lui 0x12345 → ImmExtE=0x1234_5000
  - sw offset −4 → ImmExtE=0xFFFF_FFFC, MemWriteE=1
  - jal +2048 → ImmExtE=0x800, JumpE=1, ResultSrcE=10
  - illegal opcode 0x0000007F → all enables 0
